// File: rtl/connect_box_16x10_const.sv
// rtl/connect_box_16x10_const.sv - CGRA connection box: nine 16-bit tracks plus constant onto one output
//
// Purpose: selects one of tracks 0-4/6-9 or a configured 16-bit constant onto
// out. SEL (addr 0) and CONST (addr 1) are config registers on the shared bus.
//
// Ports:
//   clk          rising-edge clock for config registers
//   reset        asynchronous active-high reset (SEL=7, CONST=0)
//   config_addr  32-bit config register address, fully decoded
//   config_data  32-bit config write data
//   config_en    config write qualifier, sampled per rising edge
//   in_0..in_9   16-bit routing tracks (no in_5: track 5 absent)
//   out          selected value, combinational
//   read_data    combinational readback of register at config_addr
module connect_box_16x10_const (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] config_addr,
    input  logic [31:0] config_data,
    input  logic        config_en,
    input  logic [15:0] in_0,
    input  logic [15:0] in_1,
    input  logic [15:0] in_2,
    input  logic [15:0] in_3,
    input  logic [15:0] in_4,
    input  logic [15:0] in_6,
    input  logic [15:0] in_7,
    input  logic [15:0] in_8,
    input  logic [15:0] in_9,
    output logic [15:0] out,
    output logic [31:0] read_data
);

    localparam logic [31:0] SEL_ADDR      = 32'd0;
    localparam logic [31:0] CONST_ADDR    = 32'd1;
    localparam logic [3:0]  DEFAULT_VALUE = 4'd7;
    localparam logic [3:0]  CONST_SEL     = 4'd10;

    logic [3:0]  sel_q, sel_d;
    logic [15:0] const_q, const_d;

    // Data bits above each register field are ignored on write.
    logic unused_data_bits;
    assign unused_data_bits = ^config_data[31:16];

    always_comb begin
        sel_d   = sel_q;
        const_d = const_q;
        if (config_en && (config_addr == SEL_ADDR)) begin
            sel_d = config_data[3:0];
        end
        if (config_en && (config_addr == CONST_ADDR)) begin
            const_d = config_data[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= DEFAULT_VALUE;
            const_q <= 16'h0000;
        end else begin
            sel_q   <= sel_d;
            const_q <= const_d;
        end
    end

    // Track 5 and selects 11-15 have no source and drive zero.
    always_comb begin
        out = 16'h0000;
        case (sel_q)
            4'd0:      out = in_0;
            4'd1:      out = in_1;
            4'd2:      out = in_2;
            4'd3:      out = in_3;
            4'd4:      out = in_4;
            4'd6:      out = in_6;
            4'd7:      out = in_7;
            4'd8:      out = in_8;
            4'd9:      out = in_9;
            CONST_SEL: out = const_q;
            default:   out = 16'h0000;
        endcase
    end

    always_comb begin
        read_data = 32'h0000_0000;
        if (config_addr == SEL_ADDR) begin
            read_data = {28'b0, sel_q};
        end else if (config_addr == CONST_ADDR) begin
            read_data = {16'b0, const_q};
        end
    end

endmodule

// File: tb/tb_connect_box_16x10_const.sv
// tb/tb_connect_box_16x10_const.sv - directed self-checking bench for connect_box_16x10_const
module tb_connect_box_16x10_const;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic [15:0] in_0, in_1, in_2, in_3, in_4, in_6, in_7, in_8, in_9;
    logic [15:0] out;
    logic [31:0] read_data;

    int tests_run;
    int tests_failed;

    connect_box_16x10_const dut (
        .clk         (clk),
        .reset       (reset),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_en   (config_en),
        .in_0        (in_0),
        .in_1        (in_1),
        .in_2        (in_2),
        .in_3        (in_3),
        .in_4        (in_4),
        .in_6        (in_6),
        .in_7        (in_7),
        .in_8        (in_8),
        .in_9        (in_9),
        .out         (out),
        .read_data   (read_data)
    );

    initial clk = 1'b0;
    always begin
        #5;
        clk = clk_en ? ~clk : 1'b0;
    end

    task automatic set_all(input logic [15:0] v);
        in_0 = v; in_1 = v; in_2 = v; in_3 = v; in_4 = v;
        in_6 = v; in_7 = v; in_8 = v; in_9 = v;
    endtask

    task automatic set_distinct();
        in_0 = 16'h1000; in_1 = 16'h1111; in_2 = 16'h2222; in_3 = 16'h3333;
        in_4 = 16'h4444; in_6 = 16'h6666; in_7 = 16'h7777; in_8 = 16'h8888;
        in_9 = 16'h9999;
    endtask

    // One write captured by exactly one rising edge; leaves addr at 0, en low.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        config_addr = addr;
        config_data = data;
        config_en   = 1'b1;
        @(negedge clk);
        config_en   = 1'b0;
        config_addr = 32'd0;
        #1;
    endtask

    task automatic test_reset();
        set_all(16'h0000);
        in_7 = 16'h00AA;
        config_addr = 32'd0;
        config_data = 32'd0;
        config_en   = 1'b0;
        reset = 1'b0;
        #3 reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (out !== 16'h00AA) begin
            tests_failed++;
            $display("FAIL reset_out: got %h expected %h", out, 16'h00AA);
        end
        tests_run++;
        if (read_data !== 32'h7) begin
            tests_failed++;
            $display("FAIL reset_sel_read: got %h expected %h", read_data, 32'h7);
        end
        config_addr = 32'd1;
        #1;
        tests_run++;
        if (read_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_const_read: got %h expected %h", read_data, 32'h0);
        end
        config_addr = 32'd5;
        #1;
        tests_run++;
        if (read_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_other_addr: got %h expected %h", read_data, 32'h0);
        end
        config_addr = 32'd0;
    endtask

    task automatic test_track_select();
        set_distinct();
        @(negedge clk);
        config_addr = 32'd0;
        config_data = 32'h1;
        config_en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        config_en   = 1'b0;
        in_1 = 16'h0004;
        #1;
        tests_run++;
        if (out !== 16'h0004) begin
            tests_failed++;
            $display("FAIL track1_out: got %h expected %h", out, 16'h0004);
        end
        in_1 = 16'h5A5A;
        #1;
        tests_run++;
        if (out !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL track1_comb_follow: got %h expected %h", out, 16'h5A5A);
        end
        tests_run++;
        if (read_data !== 32'h1) begin
            tests_failed++;
            $display("FAIL track1_read: got %h expected %h", read_data, 32'h1);
        end
        set_distinct();
        do_write(32'd0, 32'h0);
        tests_run++;
        if (out !== 16'h1000) begin
            tests_failed++;
            $display("FAIL track0_out: got %h expected %h", out, 16'h1000);
        end
        do_write(32'd0, 32'h9);
        tests_run++;
        if (out !== 16'h9999) begin
            tests_failed++;
            $display("FAIL track9_out: got %h expected %h", out, 16'h9999);
        end
        // Upper data bits must be ignored: 0xFFFFFFF6 selects track 6.
        do_write(32'd0, 32'hFFFF_FFF6);
        tests_run++;
        if (out !== 16'h6666) begin
            tests_failed++;
            $display("FAIL track6_unused_bits: got %h expected %h", out, 16'h6666);
        end
    endtask

    task automatic test_constant();
        set_distinct();
        do_write(32'd1, 32'hABCD_1234);
        do_write(32'd0, 32'hA);
        tests_run++;
        if (out !== 16'h1234) begin
            tests_failed++;
            $display("FAIL const_out: got %h expected %h", out, 16'h1234);
        end
        set_all(16'hFFFF);
        #1;
        tests_run++;
        if (out !== 16'h1234) begin
            tests_failed++;
            $display("FAIL const_ignores_inputs: got %h expected %h", out, 16'h1234);
        end
        config_addr = 32'd1;
        #1;
        tests_run++;
        if (read_data !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL const_read: got %h expected %h", read_data, 32'h0000_1234);
        end
        config_addr = 32'd0;
    endtask

    task automatic test_invalid_select();
        set_all(16'hFFFF);
        do_write(32'd0, 32'h5);
        tests_run++;
        if (out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL sel5_out: got %h expected %h", out, 16'h0000);
        end
        do_write(32'd0, 32'hF);
        tests_run++;
        if (out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL sel15_out: got %h expected %h", out, 16'h0000);
        end
        do_write(32'd0, 32'hB);
        tests_run++;
        if (out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL sel11_out: got %h expected %h", out, 16'h0000);
        end
    endtask

    task automatic test_qualification();
        set_distinct();
        do_write(32'd0, 32'h7);
        do_write(32'd2, 32'h3);
        tests_run++;
        if (read_data !== 32'h7) begin
            tests_failed++;
            $display("FAIL addr2_ignored: got %h expected %h", read_data, 32'h7);
        end
        // Full 32-bit compare: high address bits set must not alias addr 0/1.
        do_write(32'h0001_0000, 32'h3);
        do_write(32'h8000_0001, 32'h5555);
        tests_run++;
        if (read_data !== 32'h7) begin
            tests_failed++;
            $display("FAIL highaddr_sel: got %h expected %h", read_data, 32'h7);
        end
        config_addr = 32'd1;
        #1;
        tests_run++;
        if (read_data !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL highaddr_const: got %h expected %h", read_data, 32'h0000_1234);
        end
        @(negedge clk);
        config_addr = 32'd0;
        config_data = 32'h3;
        config_en   = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (read_data !== 32'h7 || out !== 16'h7777) begin
            tests_failed++;
            $display("FAIL en_low_hold: got sel %h out %h expected sel 7 out 7777", read_data, out);
        end
        do_write(32'd0, 32'h7);
        do_write(32'd0, 32'h7);
        tests_run++;
        if (read_data !== 32'h7 || out !== 16'h7777) begin
            tests_failed++;
            $display("FAIL idempotent: got sel %h out %h expected sel 7 out 7777", read_data, out);
        end
    endtask

    task automatic test_async_reset();
        set_distinct();
        do_write(32'd0, 32'h3);
        tests_run++;
        if (out !== 16'h3333) begin
            tests_failed++;
            $display("FAIL pre_reset_sel3: got %h expected %h", out, 16'h3333);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (out !== 16'h7777) begin
            tests_failed++;
            $display("FAIL async_reset_out: got %h expected %h", out, 16'h7777);
        end
        config_addr = 32'd1;
        #1;
        tests_run++;
        if (read_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset_const: got %h expected %h", read_data, 32'h0);
        end
        config_addr = 32'd0;
        config_data = 32'h2;
        config_en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (read_data !== 32'h7) begin
            tests_failed++;
            $display("FAIL write_during_reset: got %h expected %h", read_data, 32'h7);
        end
        // Write held across deassertion lands on the first edge with reset low.
        reset = 1'b0;
        @(posedge clk);
        #1;
        config_en = 1'b0;
        tests_run++;
        if (out !== 16'h2222) begin
            tests_failed++;
            $display("FAIL first_write_after_reset: got %h expected %h", out, 16'h2222);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clk_en       = 1'b0;
        test_reset();
        clk_en = 1'b1;
        test_track_select();
        test_constant();
        test_invalid_select();
        test_qualification();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
